// File: rtl/code_search_ctrl_pkg.sv
// Shared definitions for the code-phase sweep controller: state encoding,
// field widths and the half-chip length of one GPS C/A code period.
package code_search_ctrl_pkg;

  localparam int HC_PER_GPS_CODE = 2046;
  localparam int PRN_KEY_W       = 10;
  localparam int SLEW_W          = 11;
  localparam int DWELL_W         = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_DWELL,
    ST_COMPARE,
    ST_STEP,
    ST_DONE
  } search_state_e;

  // A programmed dwell of zero would never complete a bin, so it behaves as one dump.
  function automatic logic [DWELL_W-1:0] effDwell(input logic [DWELL_W-1:0] dwell);
    return (dwell == '0) ? DWELL_W'(1) : dwell;
  endfunction

endpackage

// File: rtl/code_search_ctrl_if.sv
// Channel-side bundle of the sweep controller: register inputs, energy stream,
// code generator controls and sweep results. Prefixes are from the controller's view.
interface code_search_ctrl_if #(
  parameter int ENERGY_W = 32
);

  logic                i_start;
  logic                i_abort;
  logic [9:0]          i_prn_key_in;
  logic [3:0]          i_dwell;
  logic [ENERGY_W-1:0] i_threshold;
  logic                i_energy_valid;
  logic [ENERGY_W-1:0] i_energy;
  logic                o_prn_key_enable;
  logic [9:0]          o_prn_key;
  logic                o_slew_enable;
  logic [10:0]         o_code_slew;
  logic                o_busy;
  logic                o_done;
  logic                o_detected;
  logic [10:0]         o_best_phase;
  logic [ENERGY_W-1:0] o_best_energy;

  modport master (
    output i_start, i_abort, i_prn_key_in, i_dwell, i_threshold, i_energy_valid, i_energy,
    input  o_prn_key_enable, o_prn_key, o_slew_enable, o_code_slew, o_busy, o_done,
           o_detected, o_best_phase, o_best_energy
  );

  modport slave (
    input  i_start, i_abort, i_prn_key_in, i_dwell, i_threshold, i_energy_valid, i_energy,
    output o_prn_key_enable, o_prn_key, o_slew_enable, o_code_slew, o_busy, o_done,
           o_detected, o_best_phase, o_best_energy
  );

endinterface

// File: rtl/code_search_ctrl_sat_accum.sv
// Saturating energy accumulator with synchronous clear; a sum that would wrap
// sticks at all-ones so a very strong bin can never look weak.
module code_search_ctrl_sat_accum #(
  parameter int ENERGY_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_add,
  input  logic [ENERGY_W-1:0] i_value,
  output logic [ENERGY_W-1:0] o_acc
);

  logic [ENERGY_W-1:0] r_acc;
  logic [ENERGY_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_value};

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= w_sum[ENERGY_W] ? '1 : w_sum[ENERGY_W-1:0];
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/code_search_ctrl.sv
// Acquisition code-phase sweep controller: loads a PRN key, slews the code
// generator bin by bin, integrates dump energies and keeps the strongest bin.
module code_search_ctrl
  import code_search_ctrl_pkg::*;
#(
  parameter int NUM_BINS     = HC_PER_GPS_CODE,
  parameter int STEP_HC      = 1,
  parameter int SETTLE_DUMPS = 2,
  parameter int ENERGY_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  code_search_ctrl_if.slave  bus
);

  localparam int SET_W = (SETTLE_DUMPS < 2) ? 1 : $clog2(SETTLE_DUMPS);

  search_state_e          r_state;
  logic [SET_W-1:0]       r_settleCnt;
  logic [DWELL_W-1:0]     r_dwellCnt;
  logic [DWELL_W-1:0]     r_dwell;
  logic [SLEW_W-1:0]      r_bin;
  logic [SLEW_W-1:0]      r_phase;
  logic [PRN_KEY_W-1:0]   r_prnKey;
  logic                   r_prnKeyEn;
  logic                   r_slewEn;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_detected;
  logic [SLEW_W-1:0]      r_bestPhase;
  logic [ENERGY_W-1:0]    r_bestEnergy;

  logic [ENERGY_W-1:0]    w_acc;
  logic                   w_settleLast;
  logic                   w_dwellLast;
  logic                   w_accClear;
  logic                   w_accAdd;
  logic                   w_accWins;
  logic [ENERGY_W-1:0]    w_newBest;

  assign w_settleLast = (r_settleCnt == SET_W'(SETTLE_DUMPS - 1));
  assign w_dwellLast  = ((r_dwellCnt + DWELL_W'(1)) == r_dwell);
  assign w_accClear   = (r_state == ST_SETTLE) && bus.i_energy_valid && w_settleLast && !bus.i_abort;
  assign w_accAdd     = (r_state == ST_DWELL) && bus.i_energy_valid && !bus.i_abort;
  assign w_accWins    = (w_acc > r_bestEnergy);
  assign w_newBest    = w_accWins ? w_acc : r_bestEnergy;

  code_search_ctrl_sat_accum #(
    .ENERGY_W (ENERGY_W)
  ) u_accum (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_accClear),
    .i_add   (w_accAdd),
    .i_value (bus.i_energy),
    .o_acc   (w_acc)
  );

  // Strobes are set on the transition into their state so they coincide with it;
  // r_phase tracks bin*STEP_HC modulo 2^11 without a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_settleCnt  <= '0;
      r_dwellCnt   <= '0;
      r_dwell      <= '0;
      r_bin        <= '0;
      r_phase      <= '0;
      r_prnKey     <= '0;
      r_prnKeyEn   <= 1'b0;
      r_slewEn     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_detected   <= 1'b0;
      r_bestPhase  <= '0;
      r_bestEnergy <= '0;
    end else begin
      r_prnKeyEn <= 1'b0;
      r_slewEn   <= 1'b0;
      r_done     <= 1'b0;
      if (bus.i_abort) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.i_start) begin
              r_state      <= ST_LOAD;
              r_busy       <= 1'b1;
              r_prnKeyEn   <= 1'b1;
              r_prnKey     <= bus.i_prn_key_in;
              r_dwell      <= effDwell(bus.i_dwell);
              r_bin        <= '0;
              r_phase      <= '0;
              r_bestEnergy <= '0;
              r_bestPhase  <= '0;
              r_detected   <= 1'b0;
            end
          end
          ST_LOAD: begin
            r_settleCnt <= '0;
            r_state     <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (bus.i_energy_valid) begin
              if (w_settleLast) begin
                r_settleCnt <= '0;
                r_dwellCnt  <= '0;
                r_state     <= ST_DWELL;
              end else begin
                r_settleCnt <= r_settleCnt + SET_W'(1);
              end
            end
          end
          ST_DWELL: begin
            if (bus.i_energy_valid) begin
              r_dwellCnt <= r_dwellCnt + DWELL_W'(1);
              if (w_dwellLast) begin
                r_state <= ST_COMPARE;
              end
            end
          end
          ST_COMPARE: begin
            // Strict compare keeps the earliest bin on equal energies.
            if (w_accWins) begin
              r_bestEnergy <= w_acc;
              r_bestPhase  <= r_phase;
            end
            r_detected <= (w_newBest >= bus.i_threshold);
            if (r_bin == SLEW_W'(NUM_BINS - 1)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_STEP;
              r_slewEn <= 1'b1;
            end
          end
          ST_STEP: begin
            r_bin       <= r_bin + SLEW_W'(1);
            r_phase     <= r_phase + SLEW_W'(STEP_HC);
            r_settleCnt <= '0;
            r_state     <= ST_SETTLE;
          end
          ST_DONE: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.o_prn_key_enable = r_prnKeyEn;
  assign bus.o_prn_key        = r_prnKey;
  assign bus.o_slew_enable    = r_slewEn;
  assign bus.o_code_slew      = SLEW_W'(STEP_HC);
  assign bus.o_busy           = r_busy;
  assign bus.o_done           = r_done;
  assign bus.o_detected       = r_detected;
  assign bus.o_best_phase     = r_bestPhase;
  assign bus.o_best_energy    = r_bestEnergy;

endmodule
